// File: rtl/lsu_mem_master_if.sv
// Bus bundle for lsu_mem_master: core-side request/response channels and the
// word-organised data memory port.
//
// Handshake rule for both channels: a transfer happens at a rising clock edge
// where valid and ready are both high. While valid is high without ready, the
// sender holds its payload stable. The request channel is accepted only while
// the block is idle. The response channel holds its payload until it is
// taken.
interface lsu_mem_master_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wd;
   logic              mem_we;
   logic [31:0]       mem_rd;

   // Load/store unit side: takes requests, drives memory and responses.
   modport master (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output req_ready,
      output resp_valid, resp_rdata, resp_err,
      input  resp_ready,
      output mem_addr, mem_wd, mem_we,
      input  mem_rd
   );

   // Environment side: core request source, response sink and data memory.
   modport slave (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_err,
      output resp_ready,
      input  mem_addr, mem_wd, mem_we,
      output mem_rd
   );
endinterface

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: byte/halfword/word load-store initiator in front of a
// word-only data memory (combinational read, synchronous word write).
// Sub-word stores are done as read-modify-write. Requests outside the
// memory or with the reserved size are rejected with resp_err.
// Optional macro LSU_ALIGN_CHECK_EN: when defined, misaligned halfword/word
// requests are rejected. Otherwise the low address bits are truncated to
// natural alignment.
module lsu_mem_master #(
   parameter int MEM_WORDS = 64,
   parameter int ADDR_W    = 32
) (
   input  logic                clk,
   input  logic                reset,
   lsu_mem_master_if.master    bus,
   output logic [1:0]          dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [ADDR_W-3:0] IDX_LIMIT = (ADDR_W-2)'(MEM_WORDS);

   state_t            state_q;
   logic              we_q;
   logic [1:0]        size_q;
   logic              signed_q;
   logic [1:0]        lane_q;
   logic [15:0]       wdata_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wd_q;
   logic              mem_we_q;
   logic              resp_valid_q;
   logic [31:0]       resp_rdata_q;
   logic              resp_err_q;

   logic              acc_err_d;
   logic [1:0]        acc_lane_d;
   logic [7:0]        byte_sel_d;
   logic [15:0]       half_sel_d;
   logic [31:0]       load_d;
   logic [31:0]       merge_d;

   // Request classification: rejection reasons and effective byte lane.
   always_comb begin
      acc_err_d = (bus.req_size == 2'b11) ||
                  (bus.req_addr[ADDR_W-1:2] >= IDX_LIMIT);
`ifdef LSU_ALIGN_CHECK_EN
      if ((bus.req_size == 2'b01) && bus.req_addr[0]) begin
         acc_err_d = 1'b1;
      end
      if ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00)) begin
         acc_err_d = 1'b1;
      end
`endif
      // Truncation to natural alignment; a no-op for aligned requests.
      case (bus.req_size)
         2'b00:   acc_lane_d = bus.req_addr[1:0];
         2'b01:   acc_lane_d = {bus.req_addr[1], 1'b0};
         default: acc_lane_d = 2'b00;
      endcase
   end

   // Lane extraction for loads and lane merge for sub-word stores.
   always_comb begin
      byte_sel_d = 8'(bus.mem_rd >> {lane_q, 3'b000});
      half_sel_d = lane_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
      case (size_q)
         2'b00:   load_d = {{24{signed_q & byte_sel_d[7]}}, byte_sel_d};
         2'b01:   load_d = {{16{signed_q & half_sel_d[15]}}, half_sel_d};
         default: load_d = bus.mem_rd;
      endcase
      merge_d = bus.mem_rd;
      if (size_q == 2'b00) begin
         case (lane_q)
            2'b00:   merge_d = {bus.mem_rd[31:8], wdata_q[7:0]};
            2'b01:   merge_d = {bus.mem_rd[31:16], wdata_q[7:0], bus.mem_rd[7:0]};
            2'b10:   merge_d = {bus.mem_rd[31:24], wdata_q[7:0], bus.mem_rd[15:0]};
            default: merge_d = {wdata_q[7:0], bus.mem_rd[23:0]};
         endcase
      end else begin
         merge_d = lane_q[1] ? {wdata_q, bus.mem_rd[15:0]}
                             : {bus.mem_rd[31:16], wdata_q};
      end
   end

   // Control FSM with registered memory and response outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         size_q       <= 2'b00;
         signed_q     <= 1'b0;
         lane_q       <= 2'b00;
         wdata_q      <= 16'h0;
         mem_addr_q   <= '0;
         mem_wd_q     <= 32'h0;
         mem_we_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q         <= bus.req_we;
                  size_q       <= bus.req_size;
                  signed_q     <= bus.req_signed;
                  lane_q       <= acc_lane_d;
                  wdata_q      <= bus.req_wdata[15:0];
                  mem_addr_q   <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                  resp_rdata_q <= 32'h0;
                  resp_err_q   <= 1'b0;
                  if (acc_err_d) begin
                     resp_err_q   <= 1'b1;
                     resp_valid_q <= 1'b1;
                     state_q      <= RESP;
                  end else if (bus.req_we && (bus.req_size == 2'b10)) begin
                     mem_wd_q <= bus.req_wdata;
                     mem_we_q <= 1'b1;
                     state_q  <= WRITE;
                  end else begin
                     state_q <= READ;
                  end
               end
            end
            READ: begin
               if (we_q) begin
                  mem_wd_q <= merge_d;
                  mem_we_q <= 1'b1;
                  state_q  <= WRITE;
               end else begin
                  resp_rdata_q <= load_d;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end
            end
            WRITE: begin
               mem_we_q     <= 1'b0;
               resp_valid_q <= 1'b1;
               state_q      <= RESP;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wd     = mem_wd_q;
   assign bus.mem_we     = mem_we_q;
   assign dbg_state_o    = state_q;

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the core's memory stage and the word-organised data memory.
- The data memory has a combinational read, a synchronous word write with a WE strobe, and word addressing via addr[31:2]. It has no byte enables.
- This block supplies byte and halfword access on top of it. Loads use lane extraction with sign or zero extension. Sub-word stores use a multi-cycle read-modify-write sequence.
- It checks address range and alignment, and returns results over a valid/ready response handshake.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the attached data memory. A word index of MEM_WORDS or more is out of range.
- ADDR_W, 32, byte-address width on both sides.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request. High only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  request rejected. No memory write is performed.
- mem_addr  out  ADDR_W  byte address to the data memory; always word-aligned (bits [1:0] = 0).
- mem_wd  out  32  write data to the data memory.
- mem_we  out  1  write strobe to the data memory.
- mem_rd  in  32  combinational read data from the data memory.

Behaviour:
- Reset values (asynchronous): state = IDLE, mem_we = 0, mem_addr = 0, mem_wd = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0.
- req_ready is combinational: high exactly in IDLE, so it is 1 while reset is asserted.
- States: IDLE, READ, WRITE, RESP.
- Accept: a request is taken when req_valid && req_ready at a rising edge. At that edge the block registers size, signed, byte lane addr[1:0], store data and the word-aligned address. mem_addr takes the aligned address.
- Error check at accept. An error is raised when any of these holds:
  - size = 11;
  - word index ≥ MEM_WORDS;
  - misalignment (halfword with addr[0] = 1, or word with addr[1:0] ≠ 0). This check applies only when LSU_ALIGN_CHECK_EN is defined.
- On an error: go directly to RESP with resp_err = 1 and resp_rdata = 0. Memory is never written.
- Transitions from IDLE on accept:
  - load → READ;
  - word store → WRITE, with mem_wd = req_wdata;
  - byte or halfword store → READ.
- READ (one cycle): mem_addr is stable and mem_rd is sampled at the end of the cycle.
  - Load: extract the lane (little-endian; byte at lane×8, halfword at lane[1]×16), extend it, write it to resp_rdata, then go to RESP.
  - Sub-word store: mem_wd = mem_rd with the addressed lane replaced by req_wdata[7:0] or [15:0]; go to WRITE.
- WRITE (one cycle): mem_we = 1. The data memory writes at the edge that ends this cycle. mem_we is 0 in every other state. Next state is RESP.
- RESP: resp_valid = 1 and outputs are held until resp_ready. On resp_valid && resp_ready, go to IDLE and clear resp_valid. A new request can be accepted on the following cycle.
- Latency from accept edge to resp_valid:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Backpressure: req_valid while the block is not in IDLE is ignored. Requests are never queued.
- Reset mid-operation: the state is cleared immediately. mem_we drops asynchronously, so no write happens at the next edge. The in-flight response is discarded.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined: misaligned halfword or word requests return resp_err = 1 with no memory access.
- Undefined: low address bits are truncated to natural alignment (halfword lane = addr[1], word lane = 0). The access proceeds without error.

Test Plan:
- Word load: mem[3] = 0x8899AABB, load size 10 at addr 0x0C → resp_valid 2 cycles after accept; resp_rdata = 0x8899AABB; resp_err = 0.
- Signed byte load: same word, byte load at 0x0D with req_signed = 1 → 0xFFFFFFAA; with req_signed = 0 → 0x000000AA.
- Sub-word store: mem[2] = 0x11223344, halfword store 0xBEEF at 0x0A → exactly one mem_we pulse, 2 cycles after accept, with mem_wd = 0xBEEF3344; resp_valid on the next cycle; a later word load of 0x08 returns 0xBEEF3344.
- Errors: load at 0x100 (word 64) → resp_err = 1 one cycle after accept, mem_we never asserted. With LSU_ALIGN_CHECK_EN, word load at 0x06 → resp_err = 1; without it, the same request returns mem[1].
- Backpressure: hold resp_ready = 0 for 5 cycles in RESP → resp_valid and resp_rdata stable, req_ready = 0, and a second req_valid is ignored.
- Reset abort: assert reset during WRITE of a byte store → mem_we falls in the same cycle, the memory word is unchanged, and after release the outputs are at reset values and req_ready = 1.
